// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg
//   Shared definitions for the PC fetch sequencer:
//   - ADDR_W / INSTR_W : program-counter and instruction widths
//   - PC_INCR          : sequential PC step (3-byte instructions)
//   - state_t          : sequencer FSM state encoding
//   - pick_target      : redirect target selection (Jump beats Branch)
package pc_seq_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 24;
    localparam int PC_INCR = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } state_t;

    // An unconditional jump always wins over a taken branch.
    function automatic logic [ADDR_W-1:0] pick_target(
        input logic              jump,
        input logic [ADDR_W-1:0] jump_target,
        input logic [ADDR_W-1:0] branch_target
    );
        return jump ? jump_target : branch_target;
    endfunction

endpackage

// File: rtl/PC_Add_3.sv
// PC_Add_3
//   Sequential program-counter increment: pc_plus3 = pc + PC_INCR, wrapping
//   modulo 2^ADDR_W (16'hFFFD -> 16'h0000, 16'hFFFE -> 16'h0001).
//
//   Ports
//     pc        in   ADDR_W  current program counter
//     pc_plus3  out  ADDR_W  next sequential program counter
module PC_Add_3
    import pc_seq_pkg::*;
(
    input  logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus3
);

    // The carry out of the top bit is dropped on purpose: the PC wraps.
    assign pc_plus3 = pc + ADDR_W'(PC_INCR);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// pc_fetch_sequencer
//   Program-counter sequencer that issues instruction fetches, waits for the
//   memory acknowledge, presents the fetched instruction to decode and then
//   advances the PC by 3 or redirects it on a jump / taken branch.
//
//   Optional feature: define PC_SEQ_INT_EN to add the interrupt ports
//   (Int_Req, Int_Ack, EPC). Without it the block has no interrupt logic.
//
//   Parameters
//     RESET_VECTOR  PC loaded by reset
//     INT_VECTOR    interrupt handler address (only used with PC_SEQ_INT_EN)
//
//   Ports
//     clk, rst_n                     clock, synchronous active-low reset
//     Stall                          hold before issuing the next fetch
//     Branch_Taken / Branch_Target   conditional redirect
//     Jump / Jump_Target             unconditional redirect (higher priority)
//     Fetch_Req / Fetch_Addr         fetch request to instruction memory
//     Fetch_Ack / Fetch_Data         memory acknowledge and returned word
//     Instr_Valid / Instr_Out /
//     Instr_PC / Instr_Ready         fetched instruction towards decode
//     PC_Out                         architectural PC
//     Int_Req / Int_Ack / EPC        interrupt request, one-cycle acknowledge,
//                                    saved return PC (PC_SEQ_INT_EN only)
//     dbg_state                      current FSM state, for observation
//
//   Handshakes: a fetch completes on the rising edge where Fetch_Req and
//   Fetch_Ack are both high; Fetch_Req/Fetch_Addr stay stable until then.
//   An instruction is consumed on the rising edge where Instr_Valid and
//   Instr_Ready are both high; Instr_Out/Instr_PC stay stable until then.
//   A redirect seen while an instruction is presented flushes it instead.
module pc_fetch_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 16'h0000,
    parameter logic [ADDR_W-1:0] INT_VECTOR   = 16'h0010
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               Stall,
    input  logic               Branch_Taken,
    input  logic [ADDR_W-1:0]  Branch_Target,
    input  logic               Jump,
    input  logic [ADDR_W-1:0]  Jump_Target,
    output logic               Fetch_Req,
    output logic [ADDR_W-1:0]  Fetch_Addr,
    input  logic               Fetch_Ack,
    input  logic [INSTR_W-1:0] Fetch_Data,
    output logic               Instr_Valid,
    output logic [INSTR_W-1:0] Instr_Out,
    output logic [ADDR_W-1:0]  Instr_PC,
    input  logic               Instr_Ready,
    output logic [ADDR_W-1:0]  PC_Out,
`ifdef PC_SEQ_INT_EN
    input  logic               Int_Req,
    output logic               Int_Ack,
    output logic [ADDR_W-1:0]  EPC,
`endif
    output state_t             dbg_state
);

    state_t              state;
    state_t              state_n;
    state_t              resume_state;
    logic [ADDR_W-1:0]   pc_n;
    logic [ADDR_W-1:0]   pc_plus3;
    logic [ADDR_W-1:0]   target;
    logic [ADDR_W-1:0]   fetch_addr_n;
    logic [INSTR_W-1:0]  instr_out_n;
    logic [ADDR_W-1:0]   instr_pc_n;
    logic                fetch_req_n;
    logic                instr_valid_n;
    logic                redirect;
    logic                new_req;

`ifdef PC_SEQ_INT_EN
    logic                int_ack_n;
    logic [ADDR_W-1:0]   epc_n;
`else
    // INT_VECTOR has no use without the interrupt feature.
    logic                unused_int_vector;
    assign unused_int_vector = ^INT_VECTOR;
`endif

    assign dbg_state = state;

    PC_Add_3 u_pc_add_3 (
        .pc       (PC_Out),
        .pc_plus3 (pc_plus3)
    );

    // ------------------------------------------------------------------
    // Next-state and next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_n      = state;
        pc_n         = PC_Out;
        fetch_addr_n = Fetch_Addr;
        instr_out_n  = Instr_Out;
        instr_pc_n   = Instr_PC;
        redirect     = Jump | Branch_Taken;
        target       = pick_target(Jump, Jump_Target, Branch_Target);
        // Where to go once the current step is finished: Stall only
        // decides whether the next fetch is issued right away.
        resume_state = Stall ? IDLE : REQ;
`ifdef PC_SEQ_INT_EN
        int_ack_n    = 1'b0;
        epc_n        = EPC;
`endif

        case (state)
            IDLE: begin
                if (redirect) begin
                    pc_n = target;
                end
                state_n = resume_state;
            end

            REQ: begin
                // The request is already on the bus, so Stall is ignored
                // until it is acknowledged.
                if (Fetch_Ack) begin
                    if (redirect) begin
                        // Returned word belongs to the abandoned path.
                        pc_n    = target;
                        state_n = resume_state;
                    end else begin
                        instr_out_n = Fetch_Data;
                        instr_pc_n  = Fetch_Addr;
                        state_n     = OUT;
                    end
                end else if (redirect) begin
                    // Cannot withdraw the request; wait for its ack and
                    // throw the data away.
                    pc_n    = target;
                    state_n = DRAIN;
                end
            end

            DRAIN: begin
                if (redirect) begin
                    pc_n = target;
                end
                if (Fetch_Ack) begin
                    state_n = resume_state;
                end
            end

            OUT: begin
                if (redirect) begin
                    // Presented instruction is flushed even if Instr_Ready.
                    pc_n    = target;
                    state_n = resume_state;
                end else if (Instr_Ready) begin
                    pc_n    = pc_plus3;
                    state_n = resume_state;
                end
`ifdef PC_SEQ_INT_EN
                // The interrupt is taken at the point the PC would move on;
                // the PC it would have moved to becomes the return address.
                if ((redirect || Instr_Ready) && Int_Req) begin
                    epc_n     = pc_n;
                    pc_n      = INT_VECTOR;
                    int_ack_n = 1'b1;
                end
`endif
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // A fresh request is launched when entering REQ, or when REQ loops
        // back to itself after an acknowledged (and discarded) fetch. A REQ
        // that is still waiting keeps its address stable.
        new_req = (state_n == REQ) && !((state == REQ) && !Fetch_Ack);
        if (new_req) begin
            fetch_addr_n = pc_n;
        end

        fetch_req_n   = (state_n == REQ) || (state_n == DRAIN);
        instr_valid_n = (state_n == OUT);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            PC_Out      <= RESET_VECTOR;
            Fetch_Addr  <= RESET_VECTOR;
            Fetch_Req   <= 1'b0;
            Instr_Valid <= 1'b0;
            Instr_Out   <= '0;
            Instr_PC    <= '0;
        end else begin
            state       <= state_n;
            PC_Out      <= pc_n;
            Fetch_Addr  <= fetch_addr_n;
            Fetch_Req   <= fetch_req_n;
            Instr_Valid <= instr_valid_n;
            Instr_Out   <= instr_out_n;
            Instr_PC    <= instr_pc_n;
        end
    end

`ifdef PC_SEQ_INT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Int_Ack <= 1'b0;
            EPC     <= '0;
        end else begin
            Int_Ack <= int_ack_n;
            EPC     <= epc_n;
        end
    end
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb_pc_fetch_sequencer
//   Cycle-level vectors for pc_fetch_sequencer with RESET_VECTOR = 16'h0100.
//   The instruction memory returns Fetch_Data = {~addr[7:0], addr}.
module tb_pc_fetch_sequencer;
    import pc_seq_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic               Stall         = 1'b0;
    logic               Branch_Taken  = 1'b0;
    logic [ADDR_W-1:0]  Branch_Target = '0;
    logic               Jump          = 1'b0;
    logic [ADDR_W-1:0]  Jump_Target   = '0;
    logic               Fetch_Ack     = 1'b0;
    logic               Instr_Ready   = 1'b0;
    logic               Fetch_Req;
    logic [ADDR_W-1:0]  Fetch_Addr;
    logic [INSTR_W-1:0] Fetch_Data;
    logic               Instr_Valid;
    logic [INSTR_W-1:0] Instr_Out;
    logic [ADDR_W-1:0]  Instr_PC;
    logic [ADDR_W-1:0]  PC_Out;
    state_t             dbg_state;
`ifdef PC_SEQ_INT_EN
    logic               Int_Req = 1'b0;
    logic               Int_Ack;
    logic [ADDR_W-1:0]  EPC;
`endif

    function automatic logic [INSTR_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
        return {~a[7:0], a};
    endfunction

    assign Fetch_Data = mem_word(Fetch_Addr);

    pc_fetch_sequencer #(
        .RESET_VECTOR (16'h0100),
        .INT_VECTOR   (16'h0010)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .Stall         (Stall),
        .Branch_Taken  (Branch_Taken),
        .Branch_Target (Branch_Target),
        .Jump          (Jump),
        .Jump_Target   (Jump_Target),
        .Fetch_Req     (Fetch_Req),
        .Fetch_Addr    (Fetch_Addr),
        .Fetch_Ack     (Fetch_Ack),
        .Fetch_Data    (Fetch_Data),
        .Instr_Valid   (Instr_Valid),
        .Instr_Out     (Instr_Out),
        .Instr_PC      (Instr_PC),
        .Instr_Ready   (Instr_Ready),
        .PC_Out        (PC_Out),
`ifdef PC_SEQ_INT_EN
        .Int_Req       (Int_Req),
        .Int_Ack       (Int_Ack),
        .EPC           (EPC),
`endif
        .dbg_state     (dbg_state)
    );

    // ---------------- vector records ----------------
    typedef struct {
        logic              stall;
        logic              jump;
        logic [ADDR_W-1:0] jt;
        logic              br;
        logic [ADDR_W-1:0] bt;
        logic              ack;
        logic              ready;
        logic              e_req;
        logic [ADDR_W-1:0] e_addr;
        logic              e_valid;
        logic [ADDR_W-1:0] e_pc;
    } vec_t;

    function automatic vec_t mk(
        input logic stall, input logic jump, input logic [15:0] jt,
        input logic br, input logic [15:0] bt, input logic ack, input logic ready,
        input logic e_req, input logic [15:0] e_addr, input logic e_valid,
        input logic [15:0] e_pc
    );
        vec_t v;
        v.stall = stall; v.jump = jump; v.jt = jt; v.br = br; v.bt = bt;
        v.ack = ack; v.ready = ready; v.e_req = e_req; v.e_addr = e_addr;
        v.e_valid = e_valid; v.e_pc = e_pc;
        return v;
    endfunction

    // ---------------- scoreboard ----------------
    logic [ADDR_W+INSTR_W-1:0] exp_q[$];
    int                        n_checks = 0;
    int                        n_fail   = 0;
    logic                      prev_req   = 1'b0;
    logic                      prev_valid = 1'b0;
    logic [ADDR_W-1:0]         prev_addr  = '0;
    logic                      drain_exp  = 1'b0;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, score the decode handshake, advance, check.
    task automatic step(input vec_t v, input int id);
        logic                      redir;
        logic [ADDR_W+INSTR_W-1:0] e;
        redir        = v.jump | v.br;
        Stall        = v.stall;
        Jump         = v.jump;
        Jump_Target  = v.jt;
        Branch_Taken = v.br;
        Branch_Target = v.bt;
        Fetch_Ack    = v.ack;
        Instr_Ready  = v.ready;

        if (prev_valid && redir) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
        end else if (Instr_Valid && v.ready) begin
            if (exp_q.size() == 0) begin
                check($sformatf("v%0d_sb_empty", id), 40'd1, 40'd0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("v%0d_instr_pc", id), 40'(Instr_PC), 40'(e[39:24]));
                check($sformatf("v%0d_instr_out", id), 40'(Instr_Out), 40'(e[23:0]));
            end
        end
        if (prev_req && v.ack && !redir && !drain_exp)
            exp_q.push_back({prev_addr, mem_word(prev_addr)});
        if (prev_req && !v.ack && redir) drain_exp = 1'b1;
        else if (v.ack) drain_exp = 1'b0;

        @(posedge clk);
        #1;
        check($sformatf("v%0d_fetch_req", id), 40'(Fetch_Req), 40'(v.e_req));
        check($sformatf("v%0d_fetch_addr", id), 40'(Fetch_Addr), 40'(v.e_addr));
        check($sformatf("v%0d_instr_valid", id), 40'(Instr_Valid), 40'(v.e_valid));
        check($sformatf("v%0d_pc_out", id), 40'(PC_Out), 40'(v.e_pc));
        prev_req   = v.e_req;
        prev_valid = v.e_valid;
        prev_addr  = v.e_addr;
    endtask

    // Reset with an ack and ready pending: none of it may leak through.
    task automatic do_reset(input string tag);
        rst_n = 1'b0; Fetch_Ack = 1'b1; Instr_Ready = 1'b1; Stall = 1'b0;
        Jump = 1'b0; Branch_Taken = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check({tag, "_state"}, 40'(dbg_state), 40'(IDLE));
        check({tag, "_pc_out"}, 40'(PC_Out), 40'h0100);
        check({tag, "_fetch_addr"}, 40'(Fetch_Addr), 40'h0100);
        check({tag, "_fetch_req"}, 40'(Fetch_Req), 40'd0);
        check({tag, "_instr_valid"}, 40'(Instr_Valid), 40'd0);
        check({tag, "_instr_out"}, 40'(Instr_Out), 40'd0);
        check({tag, "_instr_pc"}, 40'(Instr_PC), 40'd0);
`ifdef PC_SEQ_INT_EN
        check({tag, "_int_ack"}, 40'(Int_Ack), 40'd0);
        check({tag, "_epc"}, 40'(EPC), 40'd0);
`endif
        rst_n = 1'b1;
        exp_q.delete();
        prev_req = 1'b0; prev_valid = 1'b0; drain_exp = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl[$];
        logic [15:0] p;
        int          wa;
        int          wr;

        // mk(stall,jump,jt,br,bt,ack,ready | req,addr,valid,pc)
        // back-to-back fetches, ack in first REQ cycle, ack in IDLE ignored
        tbl.push_back(mk(0,0,16'h0,0,16'h0,1,1, 1,16'h0100,0,16'h0100));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,1,1, 0,16'h0100,1,16'h0100));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,1,1, 1,16'h0103,0,16'h0103));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,1,1, 0,16'h0103,1,16'h0103));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,1,1, 1,16'h0106,0,16'h0106));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,1,1, 0,16'h0106,1,16'h0106));
        // stall at OUT handshake -> IDLE; release -> request next cycle
        tbl.push_back(mk(1,0,16'h0,0,16'h0,1,1, 0,16'h0106,0,16'h0109));
        tbl.push_back(mk(1,0,16'h0,0,16'h0,1,0, 0,16'h0106,0,16'h0109));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,0,0, 1,16'h0109,0,16'h0109));
        // stall cannot drop a raised request nor block OUT
        tbl.push_back(mk(1,0,16'h0,0,16'h0,0,0, 1,16'h0109,0,16'h0109));
        tbl.push_back(mk(1,0,16'h0,0,16'h0,1,0, 0,16'h0109,1,16'h0109));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,0,0, 0,16'h0109,1,16'h0109));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,0,1, 1,16'h010C,0,16'h010C));
        // jump + branch in OUT: jump wins, instruction flushed
        tbl.push_back(mk(0,0,16'h0,0,16'h0,1,0, 0,16'h010C,1,16'h010C));
        tbl.push_back(mk(0,1,16'h0300,1,16'h0400,0,1, 1,16'h0300,0,16'h0300));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,1,0, 0,16'h0300,1,16'h0300));
        tbl.push_back(mk(0,0,16'h0,1,16'h0400,0,1, 1,16'h0400,0,16'h0400));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,0,0, 1,16'h0400,0,16'h0400));
        // jump in REQ, ack 3 cycles later: old address held, data dropped
        tbl.push_back(mk(0,1,16'h0200,0,16'h0,0,0, 1,16'h0400,0,16'h0200));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,0,0, 1,16'h0400,0,16'h0200));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,0,0, 1,16'h0400,0,16'h0200));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,1,1, 1,16'h0200,0,16'h0200));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,1,0, 0,16'h0200,1,16'h0200));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,0,1, 1,16'h0203,0,16'h0203));
        // second redirect while draining overwrites the PC; exit to IDLE
        tbl.push_back(mk(0,1,16'h0500,0,16'h0,0,0, 1,16'h0203,0,16'h0500));
        tbl.push_back(mk(0,0,16'h0,1,16'h0600,0,0, 1,16'h0203,0,16'h0600));
        tbl.push_back(mk(1,0,16'h0,0,16'h0,1,0, 0,16'h0203,0,16'h0600));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,0,0, 1,16'h0600,0,16'h0600));
        // redirect together with ack in REQ: new request at once
        tbl.push_back(mk(0,1,16'h0700,0,16'h0,1,0, 1,16'h0700,0,16'h0700));
        // PC wrap-around
        tbl.push_back(mk(0,1,16'hFFFD,0,16'h0,1,0, 1,16'hFFFD,0,16'hFFFD));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,1,0, 0,16'hFFFD,1,16'hFFFD));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,0,1, 1,16'h0000,0,16'h0000));
        tbl.push_back(mk(0,1,16'hFFFE,0,16'h0,1,0, 1,16'hFFFE,0,16'hFFFE));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,1,0, 0,16'hFFFE,1,16'hFFFE));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,0,1, 1,16'h0001,0,16'h0001));
        // redirect while idle
        tbl.push_back(mk(0,0,16'h0,0,16'h0,1,0, 0,16'h0001,1,16'h0001));
        tbl.push_back(mk(1,0,16'h0,0,16'h0,0,1, 0,16'h0001,0,16'h0004));
        tbl.push_back(mk(1,1,16'h0800,0,16'h0,0,0, 0,16'h0001,0,16'h0800));
        tbl.push_back(mk(0,0,16'h0,0,16'h0,0,0, 1,16'h0800,0,16'h0800));

        do_reset("rst0");
        for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);
        check("sb_drained_tbl", 40'(exp_q.size()), 40'd0);

        // reset in the middle of an outstanding fetch; ack right after release
        do_reset("rst1");
        step(mk(0,0,16'h0,0,16'h0,1,0, 1,16'h0100,0,16'h0100), 200);
        step(mk(0,0,16'h0,0,16'h0,1,0, 0,16'h0100,1,16'h0100), 201);
        step(mk(0,0,16'h0,0,16'h0,0,1, 1,16'h0103,0,16'h0103), 202);

        // random ack / ready latencies on the sequential path
        p = 16'h0103;
        for (int n = 0; n < 8; n++) begin
            wa = $urandom_range(0, 3);
            wr = $urandom_range(0, 3);
            for (int k = 0; k < wa; k++) step(mk(0,0,16'h0,0,16'h0,0,0, 1,p,0,p), 300 + n);
            step(mk(0,0,16'h0,0,16'h0,1,0, 0,p,1,p), 300 + n);
            for (int k = 0; k < wr; k++) step(mk(0,0,16'h0,0,16'h0,0,0, 0,p,1,p), 300 + n);
            p = p + 16'd3;
            step(mk(0,0,16'h0,0,16'h0,0,1, 1,p,0,p), 300 + n);
        end

`ifdef PC_SEQ_INT_EN
        // interrupt taken at the handshake of PC 0x0050
        step(mk(0,1,16'h0050,0,16'h0,1,0, 1,16'h0050,0,16'h0050), 400);
        step(mk(0,0,16'h0,0,16'h0,1,0, 0,16'h0050,1,16'h0050), 401);
        Int_Req = 1'b1;
        step(mk(0,0,16'h0,0,16'h0,0,1, 1,16'h0010,0,16'h0010), 402);
        check("int_epc", 40'(EPC), 40'h0053);
        check("int_ack_pulse", 40'(Int_Ack), 40'd1);
        Int_Req = 1'b0;
        step(mk(0,0,16'h0,0,16'h0,0,0, 1,16'h0010,0,16'h0010), 403);
        check("int_ack_drop", 40'(Int_Ack), 40'd0);
        check("int_epc_hold", 40'(EPC), 40'h0053);
`endif

        check("sb_drained_end", 40'(exp_q.size()), 40'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
